rgb_to_bayer: RTL
=================

// Module: rgb_to_bayer
// PURPOSE
//  Re-mosaics a 24-bit RGB AXI4-Stream video into an 8-bit Bayer raw stream, keeping one
//  channel per pixel according to the CFA phase. Inverse of the demosaicing kernel.
//  Sits after test-pattern/RGB sources to generate raw stimulus and loopback frames for the demosaic path.
//  Full throughput (1 pixel/clk), honours downstream backpressure.
// PARAMETERS
//  NCOLS    349  pixels per line (checker reference only)
//  NROWS    349  lines per frame (checker reference only)
//  PATTERN  0    CFA phase at row0/col0: 0=RGGB 1=GRBG 2=GBRG 3=BGGR
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  s_axis_tdata    in   24  RGB pixel {R[23:16],G[15:8],B[7:0]}
//  s_axis_tvalid   in   1   input valid
//  s_axis_tuser    in   1   start of frame (first pixel)
//  s_axis_tlast    in   1   end of line (last pixel)
//  s_axis_tready   out  1   input ready
//  m_axis_tdata    out  8   Bayer sample
//  m_axis_tvalid   out  1   output valid
//  m_axis_tuser    out  1   start of frame, aligned with m_axis_tdata
//  m_axis_tlast    out  1   end of line, aligned with m_axis_tdata
//  m_axis_tready   in   1   output ready
//  line_len_err    out  1   sticky: line length != NCOLS (checker)
//  frame_len_err   out  1   sticky: line count at SOF != NROWS (checker)
// BEHAVIOUR
//  - Reset: m_axis_tvalid/tuser/tlast=0, m_axis_tdata=0, s_axis_tready=1, counters=0, err flags=0.
//  - Input beat accepted when s_axis_tvalid & s_axis_tready. Only accepted beats advance state.
//  - Position counters col/row (12 bit):
//    - tuser beat forces col=0,row=0 for that pixel, including mid-line (frame restart).
//    - After a tlast beat: col=0, row+1. After any other beat: col+1.
//    - Counters wrap naturally at 4096; no saturation.
//  - Channel select on {row[0],col[0]} XOR PATTERN phase bits; RGGB base:
//    00->R, 01->G, 10->G, 11->B.
//    - PATTERN[0] flips col parity. PATTERN[1] flips row parity.
//  - Output stage: one output register plus a one-entry skid register.
//    - Latency = 1 clk from accepted input to m_axis_tvalid when m_axis_tready=1.
//    - s_axis_tready = !skid_full (registered).
//    - Output register stalled: incoming beat goes to skid; s_axis_tready drops the next cycle.
//    - Drain: skid moves to output when output register is consumed.
//    - No beat is dropped or duplicated.
//    - AXI rule: m_axis_tdata/tuser/tlast held stable while tvalid & !tready.
//  - tuser/tlast propagate unchanged with their pixel. Simultaneous tuser & tlast: legal (1-pixel line), col=0 then row advances.
//  - rst mid-frame: pipeline flushed, in-flight beats discarded, next pixel treated as row0/col0.
// CONFIGURATION
//  RGB2BAYER_CHECK_EN defined:
//    - On each tlast beat, line_len_err sets if col+1 != NCOLS.
//    - On each tuser beat, except the first after rst, frame_len_err sets if row != NROWS.
//    - Flags are sticky until rst. Checker does not alter the data path.
//  RGB2BAYER_CHECK_EN undefined: line_len_err=0, frame_len_err=0 constant; checker logic absent; ports remain.
// STRUCTURE
//  - Shared package bayer_pkg:
//    - CFA phase constants (BAYER_RGGB/GRBG/GBRG/BGGR).
//    - Channel byte-lane localparams (LANE_R=16, LANE_G=8, LANE_B=0).
//    - Pixel width constants (PIX_W=8, RGB_W=24).
//  - Sub-module axis_skid_buffer #(W) holds the output/skid register pair.
//    - W = 10 (data + tuser + tlast). Reusable by the demosaic path.
//  - Top holds position counters, channel mux, checker.
// TESTING
//  1 4x2 frame, PATTERN=0, pixel = {8'hA0+i, 8'h50+i, 8'h10+i}, m_tready=1
//    -> out A0,51,A2,53 / 54,15,56,17; tlast at beats 3,7; tuser at beat 0.
//  2 Same frame with PATTERN=3 -> row0 = 10,51,12,53; row1 = 54,A5,56,A7.
//  3 Continuous input, m_tready toggling 1010...
//    -> s_tready drops 1 clk after the first stall; output sequence identical to test 1; data stable while stalled.
//  4 m_tready=0 for 20 clk with s_tvalid=1 -> exactly 2 beats accepted, s_tready=0 until release, then in-order drain.
//  5 tuser asserted at col 2 of row 1 -> that pixel emitted as row0/col0 phase (R for PATTERN=0).
//    Checker build: frame_len_err=1 when NROWS!=1.
//  6 CHECK_EN, NCOLS=4, line of 3 pixels -> line_len_err=1 the cycle after tlast; stays 1; rst clears to 0.

Source files
------------

// File: rtl/bayer_pkg.sv
// Shared Bayer/RGB definitions: CFA phase codes, channel byte lanes, pixel widths
// and the phase-to-channel helper used by the re-mosaic and demosaic paths.
package bayer_pkg;

  localparam int PIX_W   = 8;
  localparam int RGB_W   = 24;
  localparam int COORD_W = 12;

  localparam int LANE_R = 16;
  localparam int LANE_G = 8;
  localparam int LANE_B = 0;

  localparam logic [1:0] BAYER_RGGB = 2'd0;
  localparam logic [1:0] BAYER_GRBG = 2'd1;
  localparam logic [1:0] BAYER_GBRG = 2'd2;
  localparam logic [1:0] BAYER_BGGR = 2'd3;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  // Bit 0 of the pattern flips column parity, bit 1 flips row parity.
  function automatic chan_e cfa_channel(input logic row_lsb, input logic col_lsb,
                                        input logic [1:0] pattern);
    logic [1:0] ph;
    ph = {row_lsb ^ pattern[1], col_lsb ^ pattern[0]};
    case (ph)
      2'b00:   return CH_R;
      2'b11:   return CH_B;
      default: return CH_G;
    endcase
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// AXI4-Stream output register plus one-entry skid register: 1-cycle latency,
// full throughput, registered upstream ready, payload stable while stalled.
module axis_skid_buffer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;
  logic         r_out_valid;
  logic         r_skid_valid;
  logic         w_in_fire;
  logic         w_out_free;

  assign w_in_fire  = i_valid & ~r_skid_valid;
  assign w_out_free = ~r_out_valid | i_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) r_out <= i_data;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload is qualified by r_skid_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!w_out_free && w_in_fire) r_skid <= i_data;
  end

  assign o_ready = ~r_skid_valid;
  assign o_data  = r_out;
  assign o_valid = r_out_valid;

endmodule

// File: rtl/rgb_to_bayer.sv
// Re-mosaics 24-bit RGB AXI4-Stream into 8-bit Bayer raw, one pixel per clock.
// Define RGB2BAYER_CHECK_EN to build the sticky line/frame length checker.
module rgb_to_bayer
  import bayer_pkg::*;
#(
  parameter int         NCOLS   = 349,
  parameter int         NROWS   = 349,
  parameter logic [1:0] PATTERN = BAYER_RGGB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             line_len_err,
  output logic             frame_len_err
);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] w_col;
  logic [COORD_W-1:0] w_row;
  logic               w_s_ready;
  logic               w_in_fire;
  chan_e              w_chan;
  logic [PIX_W-1:0]   w_pix;

  assign s_axis_tready = w_s_ready;
  assign w_in_fire     = s_axis_tvalid & w_s_ready;

  // A start-of-frame beat is itself pixel (0,0), even when it arrives mid-line.
  assign w_col = s_axis_tuser ? '0 : r_col;
  assign w_row = s_axis_tuser ? '0 : r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_in_fire) begin
      if (s_axis_tlast) begin
        r_col <= '0;
        r_row <= w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_chan = cfa_channel(w_row[0], w_col[0], PATTERN);
    w_pix  = s_axis_tdata[LANE_G +: PIX_W];
    case (w_chan)
      CH_R:    w_pix = s_axis_tdata[LANE_R +: PIX_W];
      CH_B:    w_pix = s_axis_tdata[LANE_B +: PIX_W];
      default: ;
    endcase
  end

  axis_skid_buffer #(
    .W(PIX_W + 2)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .i_data ({w_pix, s_axis_tuser, s_axis_tlast}),
    .i_valid(s_axis_tvalid),
    .o_ready(w_s_ready),
    .o_data ({m_axis_tdata, m_axis_tuser, m_axis_tlast}),
    .o_valid(m_axis_tvalid),
    .i_ready(m_axis_tready)
  );

`ifdef RGB2BAYER_CHECK_EN
  localparam logic [COORD_W-1:0] NCOLS_W = COORD_W'(NCOLS);
  localparam logic [COORD_W-1:0] NROWS_W = COORD_W'(NROWS);

  logic r_line_err;
  logic r_frame_err;
  logic r_sof_seen;

  // The first SOF after reset has no preceding frame to measure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      r_sof_seen  <= 1'b0;
    end else if (w_in_fire) begin
      if (s_axis_tlast && (w_col + 1'b1) != NCOLS_W) r_line_err <= 1'b1;
      if (s_axis_tuser) begin
        r_sof_seen <= 1'b1;
        if (r_sof_seen && r_row != NROWS_W) r_frame_err <= 1'b1;
      end
    end
  end

  assign line_len_err  = r_line_err;
  assign frame_len_err = r_frame_err;
`else
  // Geometry only matters to the checker; keep the parameters referenced.
  logic w_unused_geom;
  assign w_unused_geom = ^{NCOLS[0], NROWS[0]};

  assign line_len_err  = 1'b0;
  assign frame_len_err = 1'b0;
`endif

endmodule
